// File: rtl/shift_exec_pipe_pkg.sv
// Shared definitions for the two-stage shift execution pipeline:
// the shift opcode encoding and the datapath width.
package shift_exec_pipe_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRL  = 2'b01,
      SH_PASS = 2'b10,
      SH_SRA  = 2'b11
   } shift_op_e;

endpackage

// File: rtl/shift_exec_pipe_shift_partial.sv
// Combinational partial shifter used by both pipeline stages.
// Left shifts always fill with zero. Right shifts fill with fill_i, which the
// caller sets to the original operand sign for SRA and to 0 for SRL.
// SH_PASS returns the operand unchanged.
module shift_partial
   import shift_exec_pipe_pkg::*;
(
   input  logic [XLEN-1:0] data_i,
   input  shift_op_e       op_i,
   input  logic            fill_i,
   input  logic [4:0]      amount_i,
   output logic [XLEN-1:0] result_o
);

   logic [2*XLEN-1:0] right_wide;

   // Select the shifted value for the requested operation.
   always_comb begin
      right_wide = {{XLEN{fill_i}}, data_i} >> amount_i;
      result_o   = data_i;
      unique case (op_i)
         SH_SLL:  result_o = data_i << amount_i;
         SH_SRL,
         SH_SRA:  result_o = right_wide[XLEN-1:0];
         SH_PASS: result_o = data_i;
         default: result_o = data_i;
      endcase
   end

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage shift execution pipeline with valid/ready handshakes.
// Stage A shifts by in_shamt[4:3]*8, stage B by the residual in_shamt[2:0].
// Optional feature macro: SHIFT_ZERO_FLAG_EN adds the registered out_zero flag.
//
// Handshake: a transfer happens on a cycle where valid && ready are both high
// at the rising edge. A producer holds its payload stable while valid is high
// and ready is low; ready never depends on valid of the same interface.
module shift_exec_pipe
   import shift_exec_pipe_pkg::*;
#(
   parameter int TAG_W = 5
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_data,
   input  logic [4:0]       in_shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_ZERO_FLAG_EN
   ,
   output logic             out_zero
`endif
);

   // Stage A registers
   logic             a_valid_q, a_valid_d;
   shift_op_e        a_op_q, a_op_d;
   logic [2:0]       a_shamt_q, a_shamt_d;
   logic [TAG_W-1:0] a_tag_q, a_tag_d;
   logic             a_sign_q, a_sign_d;
   logic [XLEN-1:0]  a_data_q, a_data_d;

   // Stage B registers
   logic             b_valid_q, b_valid_d;
   logic [XLEN-1:0]  b_result_q, b_result_d;
   logic [TAG_W-1:0] b_tag_q, b_tag_d;
`ifdef SHIFT_ZERO_FLAG_EN
   logic             b_zero_q, b_zero_d;
`endif

   logic             b_advances;
   logic             in_fire;
   shift_op_e        in_op_e;
   logic             a_fill;
   logic             b_fill;
   logic [XLEN-1:0]  a_shifted;
   logic [XLEN-1:0]  b_shifted;

   assign in_op_e = shift_op_e'(in_op);
   assign a_fill  = (in_op_e == SH_SRA) & in_data[XLEN-1];
   assign b_fill  = (a_op_q == SH_SRA) & a_sign_q;

   // Stage A: coarse shift by a multiple of 8.
   shift_partial u_shift_a (
      .data_i   (in_data),
      .op_i     (in_op_e),
      .fill_i   (a_fill),
      .amount_i ({in_shamt[4:3], 3'b000}),
      .result_o (a_shifted)
   );

   // Stage B: fine shift by the residual 0..7.
   shift_partial u_shift_b (
      .data_i   (a_data_q),
      .op_i     (a_op_q),
      .fill_i   (b_fill),
      .amount_i ({2'b00, a_shamt_q}),
      .result_o (b_shifted)
   );

   // Handshake and next-state logic for both stages.
   always_comb begin
      b_advances = !b_valid_q || out_ready;
      in_ready   = !flush && (!a_valid_q || b_advances);
      in_fire    = in_valid && in_ready;

      a_valid_d  = a_valid_q;
      a_op_d     = a_op_q;
      a_shamt_d  = a_shamt_q;
      a_tag_d    = a_tag_q;
      a_sign_d   = a_sign_q;
      a_data_d   = a_data_q;
      b_valid_d  = b_valid_q;
      b_result_d = b_result_q;
      b_tag_d    = b_tag_q;
`ifdef SHIFT_ZERO_FLAG_EN
      b_zero_d   = b_zero_q;
`endif

      // A empties when it hands over (in_ready high) unless refilled.
      if (flush) begin
         a_valid_d = 1'b0;
      end else if (in_ready) begin
         a_valid_d = in_valid;
      end

      if (in_fire) begin
         a_op_d    = in_op_e;
         a_shamt_d = in_shamt[2:0];
         a_tag_d   = in_tag;
         a_sign_d  = in_data[XLEN-1];
         a_data_d  = a_shifted;
      end

      if (flush) begin
         b_valid_d = 1'b0;
      end else if (b_advances) begin
         b_valid_d = a_valid_q;
      end

      // B only captures when it can advance, so a stalled result stays put.
      if (b_advances && a_valid_q) begin
         b_result_d = b_shifted;
         b_tag_d    = a_tag_q;
`ifdef SHIFT_ZERO_FLAG_EN
         b_zero_d   = (b_shifted == '0);
`endif
      end
   end

   // Pipeline state registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q  <= 1'b0;
         a_op_q     <= SH_SLL;
         a_shamt_q  <= '0;
         a_tag_q    <= '0;
         a_sign_q   <= 1'b0;
         a_data_q   <= '0;
         b_valid_q  <= 1'b0;
         b_result_q <= '0;
         b_tag_q    <= '0;
`ifdef SHIFT_ZERO_FLAG_EN
         b_zero_q   <= 1'b0;
`endif
      end else begin
         a_valid_q  <= a_valid_d;
         a_op_q     <= a_op_d;
         a_shamt_q  <= a_shamt_d;
         a_tag_q    <= a_tag_d;
         a_sign_q   <= a_sign_d;
         a_data_q   <= a_data_d;
         b_valid_q  <= b_valid_d;
         b_result_q <= b_result_d;
         b_tag_q    <= b_tag_d;
`ifdef SHIFT_ZERO_FLAG_EN
         b_zero_q   <= b_zero_d;
`endif
      end
   end

   assign out_valid  = b_valid_q;
   assign out_result = b_result_q;
   assign out_tag    = b_tag_q;
`ifdef SHIFT_ZERO_FLAG_EN
   assign out_zero   = b_zero_q;
`endif

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed testbench for shift_exec_pipe. Honours SHIFT_ZERO_FLAG_EN.
module tb_shift_exec_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
`ifdef SHIFT_ZERO_FLAG_EN
   logic        out_zero;
`endif

   int checks;
   int failures;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_PASS = 2'b10;
   localparam logic [1:0] OP_SRA  = 2'b11;

   shift_exec_pipe #(.TAG_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_data    (in_data),
      .in_shamt   (in_shamt),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
`ifdef SHIFT_ZERO_FLAG_EN
      ,
      .out_zero   (out_zero)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock; sample #1 after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input logic [4:0] tg);
      in_valid = v;
      in_op    = op;
      in_data  = d;
      in_shamt = sh;
      in_tag   = tg;
   endtask

   task automatic chk_zero(input string tag, input logic exp);
`ifdef SHIFT_ZERO_FLAG_EN
      chk(tag, {31'd0, out_zero}, {31'd0, exp});
`else
      if (exp === 1'bx) chk(tag, 32'd0, 32'd1);
`endif
   endtask

   // one isolated transaction with latency and result checks
   task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [4:0] tg, input logic [31:0] exp);
      out_ready = 1'b1;
      drive(1'b1, op, d, sh, tg);
      #1;
      chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      drive(1'b0, 2'b00, 32'd0, 5'd0, 5'd0);
      #1;
      chk({name, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
      step();
      chk({name, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_result"}, out_result, exp);
      chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tg});
      chk_zero({name, "_zero"}, exp == 32'd0);
      step();
      chk({name, "_drained"}, {31'd0, out_valid}, 32'd0);
   endtask

   logic [1:0]  s_op  [4];
   logic [31:0] s_dat [4];
   logic [4:0]  s_sh  [4];
   logic [31:0] s_exp [4];

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 5'd0, 5'd0);

      // reset state
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
      chk_zero("rst_out_zero", 1'b0);
      step();

      // directed single vectors
      run_one("sra_31",    OP_SRA,  32'h8000_0000, 5'd31, 5'd3,  32'hFFFF_FFFF);
      run_one("sll_31",    OP_SLL,  32'h0000_0001, 5'd31, 5'd4,  32'h8000_0000);
      run_one("srl_4",     OP_SRL,  32'hF000_0000, 5'd4,  5'd5,  32'h0F00_0000);
      run_one("sra_12",    OP_SRA,  32'h8000_F000, 5'd12, 5'd6,  32'hFFF8_000F);
      run_one("srl_31",    OP_SRL,  32'h8000_0000, 5'd31, 5'd7,  32'h0000_0001);
      run_one("sra_pos31", OP_SRA,  32'h7FFF_FFFF, 5'd31, 5'd8,  32'h0000_0000);
      run_one("sra_0",     OP_SRA,  32'h8000_0001, 5'd0,  5'd9,  32'h8000_0001);
      run_one("sll_0",     OP_SLL,  32'hA5A5_5A5A, 5'd0,  5'd10, 32'hA5A5_5A5A);
      run_one("pass",      OP_PASS, 32'h1234_5678, 5'd7,  5'd11, 32'h1234_5678);
      run_one("sra_9",     OP_SRA,  32'h8000_0000, 5'd9,  5'd12, 32'hFFC0_0000);
      run_one("sll_20",    OP_SLL,  32'h0000_00FF, 5'd20, 5'd13, 32'h0FF0_0000);
      run_one("sll_zero",  OP_SLL,  32'h0000_0000, 5'd5,  5'd14, 32'h0000_0000);
      run_one("srl_nz",    OP_SRL,  32'h0000_0010, 5'd4,  5'd15, 32'h0000_0001);

      // backpressure: two held, third stalled, release in order
      out_ready = 1'b0;
      drive(1'b1, OP_SLL, 32'h0000_0001, 5'd1, 5'd10);
      step();
      drive(1'b1, OP_SRL, 32'h0000_0100, 5'd4, 5'd11);
      #1;
      chk("bp_ready_r2", {31'd0, in_ready}, 32'd1);
      step();
      drive(1'b1, OP_SRA, 32'hF000_0000, 5'd8, 5'd12);
      #1;
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold0", out_result, 32'h0000_0002);
      step();
      chk("bp_hold1", out_result, 32'h0000_0002);
      chk("bp_hold1_tag", {27'd0, out_tag}, 32'd10);
      chk("bp_ready_low1", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_hold2", out_result, 32'h0000_0002);
      chk("bp_hold2_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_release", {31'd0, in_ready}, 32'd1);
      step();
      drive(1'b0, 2'b00, 32'd0, 5'd0, 5'd0);
      #1;
      chk("bp_r2_result", out_result, 32'h0000_0010);
      chk("bp_r2_tag", {27'd0, out_tag}, 32'd11);
      step();
      chk("bp_r3_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_r3_result", out_result, 32'hFFF0_0000);
      chk("bp_r3_tag", {27'd0, out_tag}, 32'd12);
      step();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // streaming at full rate
      s_op[0] = OP_SLL;  s_dat[0] = 32'h0000_0001; s_sh[0] = 5'd8;  s_exp[0] = 32'h0000_0100;
      s_op[1] = OP_SRL;  s_dat[1] = 32'h0000_1000; s_sh[1] = 5'd9;  s_exp[1] = 32'h0000_0008;
      s_op[2] = OP_SRA;  s_dat[2] = 32'h8000_0000; s_sh[2] = 5'd1;  s_exp[2] = 32'hC000_0000;
      s_op[3] = OP_PASS; s_dat[3] = 32'hDEAD_BEEF; s_sh[3] = 5'd3;  s_exp[3] = 32'hDEAD_BEEF;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1'b1, s_op[i], s_dat[i], s_sh[i], 5'(20 + i));
         else drive(1'b0, 2'b00, 32'd0, 5'd0, 5'd0);
         #1;
         if (i < 4) chk($sformatf("st_ready%0d", i), {31'd0, in_ready}, 32'd1);
         step();
         if (i >= 1 && i <= 4) begin
            chk($sformatf("st_valid%0d", i - 1), {31'd0, out_valid}, 32'd1);
            chk($sformatf("st_result%0d", i - 1), out_result, s_exp[i - 1]);
            chk($sformatf("st_tag%0d", i - 1), {27'd0, out_tag}, 32'(20 + i - 1));
         end
      end
      chk("st_empty", {31'd0, out_valid}, 32'd0);

      // flush with both stages full and a pending request
      out_ready = 1'b0;
      drive(1'b1, OP_SLL, 32'h0000_0003, 5'd2, 5'd1);
      step();
      drive(1'b1, OP_SLL, 32'h0000_0005, 5'd2, 5'd2);
      step();
      drive(1'b1, OP_SLL, 32'h0000_0007, 5'd2, 5'd3);
      flush = 1'b1;
      #1;
      chk("fl_ready", {31'd0, in_ready}, 32'd0);
      chk("fl_pre_valid", {31'd0, out_valid}, 32'd1);
      step();
      flush = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 5'd0, 5'd0);
      #1;
      chk("fl_valid0", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("fl_quiet%0d", i), {31'd0, out_valid}, 32'd0);
      end
      run_one("post_flush", OP_SRL, 32'h0000_0080, 5'd7, 5'd17, 32'h0000_0001);

      // reset mid-stream
      out_ready = 1'b0;
      drive(1'b1, OP_PASS, 32'hCAFE_F00D, 5'd0, 5'd21);
      step();
      drive(1'b1, OP_PASS, 32'h1111_2222, 5'd0, 5'd22);
      step();
      drive(1'b0, 2'b00, 32'd0, 5'd0, 5'd0);
      chk("rs_pre_valid", {31'd0, out_valid}, 32'd1);
      chk("rs_pre_result", out_result, 32'hCAFE_F00D);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_valid", {31'd0, out_valid}, 32'd0);
      chk("rs_result", out_result, 32'd0);
      chk("rs_tag", {27'd0, out_tag}, 32'd0);
      chk_zero("rs_zero", 1'b0);
      step();
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rs_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rs_quiet%0d", i), {31'd0, out_valid}, 32'd0);
      end
      run_one("post_reset", OP_SLL, 32'h0000_0003, 5'd30, 5'd30, 32'hC000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // safety timeout
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
